// File: rtl/fare_lookup_ctrl.sv
// Round-robin sequencer for the shared fare-table RAM read port, serving two fare-query requesters.
// Define FARE_CACHE_EN to add a one-entry cache of the last valid query's price.
`timescale 1ns/1ps
module fare_lookup_ctrl #(
  parameter int RAM_LAT = 2,
  parameter int ADDR_W  = 19,
  parameter int PRICE_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [1:0]         req0_sline,
  input  logic [4:0]         req0_spoint,
  input  logic [1:0]         req0_eline,
  input  logic [4:0]         req0_epoint,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [1:0]         req1_sline,
  input  logic [4:0]         req1_spoint,
  input  logic [1:0]         req1_eline,
  input  logic [4:0]         req1_epoint,
  output logic               req1_ready,
  output logic               resp0_valid,
  output logic               resp1_valid,
  output logic [PRICE_W-1:0] resp_price,
  output logic               resp_err,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [PRICE_W-1:0] ram_dout,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic        rr;
  logic        req_id;
  logic        q_ok;
  logic [2:0]  cnt;
  logic        grant;
  logic        accept;
  logic        hit;
  logic [1:0]  sel_sline;
  logic [1:0]  sel_eline;
  logic [4:0]  sel_spoint;
  logic [4:0]  sel_epoint;
  logic [6:0]  sel_sidx;
  logic [6:0]  sel_eidx;
  logic        sel_ok;
  logic [13:0] sel_addr;

  function automatic logic [6:0] line_offset(input logic [1:0] line);
    case (line)
      2'd0:    return 7'd0;
      2'd1:    return 7'd27;
      2'd2:    return 7'd53;
      default: return 7'd82;
    endcase
  endfunction

  function automatic logic [4:0] line_last(input logic [1:0] line);
    case (line)
      2'd0:    return 5'd26;
      2'd1:    return 5'd25;
      2'd2:    return 5'd28;
      default: return 5'd17;
    endcase
  endfunction

  // rr only matters when both requesters compete; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = rr;
    else if (req1_valid)
      grant = 1'b1;
  end

  assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  assign sel_sline  = grant ? req1_sline  : req0_sline;
  assign sel_spoint = grant ? req1_spoint : req0_spoint;
  assign sel_eline  = grant ? req1_eline  : req0_eline;
  assign sel_epoint = grant ? req1_epoint : req0_epoint;
  assign sel_sidx   = line_offset(sel_sline) + 7'(sel_spoint);
  assign sel_eidx   = line_offset(sel_eline) + 7'(sel_epoint);
  assign sel_ok     = (sel_spoint <= line_last(sel_sline)) &&
                      (sel_epoint <= line_last(sel_eline)) &&
                      (sel_sidx != sel_eidx);
  assign sel_addr   = 14'(sel_sidx) * 14'd100 + 14'(sel_eidx);

`ifdef FARE_CACHE_EN
  logic               cache_vld;
  logic [6:0]         cache_sidx;
  logic [6:0]         cache_eidx;
  logic [PRICE_W-1:0] cache_price;
  logic [6:0]         q_sidx;
  logic [6:0]         q_eidx;
  logic               q_hit;

  assign hit = cache_vld && sel_ok && (sel_sidx == cache_sidx) && (sel_eidx == cache_eidx);
`else
  assign hit = 1'b0;
`endif

  // Address and read strobe are registered at accept so the RAM sees them during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr          <= 1'b0;
      req_id      <= 1'b0;
      q_ok        <= 1'b0;
      cnt         <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_price  <= '0;
      resp_err    <= 1'b0;
      ram_en      <= 1'b0;
      ram_addr    <= '0;
`ifdef FARE_CACHE_EN
      cache_vld   <= 1'b0;
      cache_sidx  <= '0;
      cache_eidx  <= '0;
      cache_price <= '0;
      q_sidx      <= '0;
      q_eidx      <= '0;
      q_hit       <= 1'b0;
`endif
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= ISSUE;
            req_id <= grant;
            rr     <= ~grant;
            q_ok   <= sel_ok;
            ram_en <= sel_ok && !hit;
            if (sel_ok && !hit)
              ram_addr <= ADDR_W'(sel_addr);
`ifdef FARE_CACHE_EN
            q_sidx <= sel_sidx;
            q_eidx <= sel_eidx;
            q_hit  <= hit;
`endif
          end
        end
        ISSUE: begin
          ram_en <= 1'b0;
          if (!q_ok) begin
            resp_price  <= '0;
            resp_err    <= 1'b1;
            resp0_valid <= !req_id;
            resp1_valid <= req_id;
            state       <= DONE;
          end
`ifdef FARE_CACHE_EN
          else if (q_hit) begin
            resp_price  <= cache_price;
            resp_err    <= 1'b0;
            resp0_valid <= !req_id;
            resp1_valid <= req_id;
            state       <= DONE;
          end
`endif
          else begin
            cnt   <= 3'(RAM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            resp_price  <= ram_dout;
            resp_err    <= 1'b0;
            resp0_valid <= !req_id;
            resp1_valid <= req_id;
            state       <= DONE;
`ifdef FARE_CACHE_EN
            cache_vld   <= 1'b1;
            cache_sidx  <= q_sidx;
            cache_eidx  <= q_eidx;
            cache_price <= ram_dout;
`endif
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fare_lookup_ctrl.sv
// Self-checking bench for fare_lookup_ctrl: directed pins plus random traffic against a cycle model.
// Expectations for the FARE_CACHE_EN build follow the same macro.
`timescale 1ns/1ps
module tb_fare_lookup_ctrl;

  localparam int RAM_LAT = 2;
  localparam int ADDR_W  = 19;
  localparam int PRICE_W = 12;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req0_valid = 1'b0;
  logic [1:0]         req0_sline = '0;
  logic [4:0]         req0_spoint = '0;
  logic [1:0]         req0_eline = '0;
  logic [4:0]         req0_epoint = '0;
  logic               req0_ready;
  logic               req1_valid = 1'b0;
  logic [1:0]         req1_sline = '0;
  logic [4:0]         req1_spoint = '0;
  logic [1:0]         req1_eline = '0;
  logic [4:0]         req1_epoint = '0;
  logic               req1_ready;
  logic               resp0_valid;
  logic               resp1_valid;
  logic [PRICE_W-1:0] resp_price;
  logic               resp_err;
  logic               ram_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [PRICE_W-1:0] ram_dout;
  logic               busy;

  always #5 clk = ~clk;

  fare_lookup_ctrl #(.RAM_LAT(RAM_LAT), .ADDR_W(ADDR_W), .PRICE_W(PRICE_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_sline(req0_sline), .req0_spoint(req0_spoint),
    .req0_eline(req0_eline), .req0_epoint(req0_epoint), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sline(req1_sline), .req1_spoint(req1_spoint),
    .req1_eline(req1_eline), .req1_epoint(req1_epoint), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_price(resp_price), .resp_err(resp_err),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PRICE_W-1:0] ram_fn(input logic [ADDR_W-1:0] a);
    if (a == 3058) return 12'd7;
    return PRICE_W'((a * 19 + 11) ^ (a >> 3));
  endfunction

  function automatic int st_off(input int l);
    case (l)
      0: return 0;
      1: return 27;
      2: return 53;
      default: return 82;
    endcase
  endfunction

  function automatic int st_len(input int l);
    case (l)
      0: return 27;
      1: return 26;
      2: return 29;
      default: return 18;
    endcase
  endfunction

  // Fare RAM: data for the address strobed by ram_en shows up RAM_LAT edges after the strobe is launched, noise otherwise.
  logic [PRICE_W:0]   ram_pipe [RAM_LAT];
  logic [PRICE_W-1:0] junk;
  always @(posedge clk) begin
    ram_pipe[0] <= ram_en ? {1'b1, ram_fn(ram_addr)} : '0;
    for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    junk <= PRICE_W'($urandom);
  end
  assign ram_dout = ram_pipe[RAM_LAT-1][PRICE_W] ? ram_pipe[RAM_LAT-1][PRICE_W-1:0] : junk;

  // Behavioural model: one outstanding query, age counts cycles since accept, response at age == lat.
  bit                 m_pend = 0;
  int                 m_age = 0;
  int                 m_lat = 0;
  bit                 m_rr = 0;
  bit                 m_id = 0;
  bit                 m_issue = 0;
  int                 m_addr = 0;
  logic [PRICE_W-1:0] m_price = '0;
  bit                 m_err = 0;
  logic [PRICE_W-1:0] m_nprice = '0;
  bit                 m_nerr = 0;
  int                 m_si = 0;
  int                 m_ei = 0;
  bit                 c_v = 0;
  int                 c_s = 0;
  int                 c_e = 0;
  logic [PRICE_W-1:0] c_p = '0;

  initial begin
    bit g;
    bit ok;
    int sl, sp, el, ep;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        m_pend = 0; m_age = 0; m_rr = 0; m_price = '0; m_err = 0; m_addr = 0; c_v = 0;
      end else if (m_pend) begin
        if (m_age == m_lat) m_pend = 0;
        else begin
          m_age++;
          if (m_age == m_lat) begin
            m_price = m_nprice;
            m_err   = m_nerr;
`ifdef FARE_CACHE_EN
            if (m_issue) begin
              c_v = 1; c_s = m_si; c_e = m_ei; c_p = m_nprice;
            end
`endif
          end
        end
      end else if (req0_valid || req1_valid) begin
        g = (req0_valid && req1_valid) ? m_rr : req1_valid;
        m_rr = !g;
        m_id = g;
        sl = g ? req1_sline : req0_sline;   sp = g ? req1_spoint : req0_spoint;
        el = g ? req1_eline : req0_eline;   ep = g ? req1_epoint : req0_epoint;
        m_si = st_off(sl) + sp;
        m_ei = st_off(el) + ep;
        ok = (sp < st_len(sl)) && (ep < st_len(el)) && (m_si != m_ei);
        m_issue = 0;
        if (!ok) begin
          m_lat = 2; m_nprice = '0; m_nerr = 1;
        end else if (c_v && c_s == m_si && c_e == m_ei) begin
          m_lat = 2; m_nprice = c_p; m_nerr = 0;
        end else begin
          m_lat = RAM_LAT + 2; m_issue = 1; m_addr = m_si * 100 + m_ei;
          m_nprice = ram_fn(ADDR_W'(m_addr)); m_nerr = 0;
        end
        m_pend = 1;
        m_age  = 1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial begin
    bit g;
    bit idle;
    @(posedge clk);
    forever begin
      @(negedge clk);
      idle = !m_pend;
      g = (req0_valid && req1_valid) ? m_rr : req1_valid;
      checkOutput("req0_ready", req0_ready, !rst && idle && req0_valid && !g);
      checkOutput("req1_ready", req1_ready, !rst && idle && req1_valid && g);
      checkOutput("busy", busy, m_pend);
      checkOutput("ram_en", ram_en, m_pend && m_age == 1 && m_issue);
      checkOutput("ram_addr", ram_addr, m_addr);
      checkOutput("resp0_valid", resp0_valid, m_pend && m_age == m_lat && !m_id);
      checkOutput("resp1_valid", resp1_valid, m_pend && m_age == m_lat && m_id);
      checkOutput("resp_price", resp_price, m_price);
      checkOutput("resp_err", resp_err, m_err);
    end
  end

  task automatic setReq(input int id, input bit v, input logic [1:0] sl, input logic [4:0] sp,
                        input logic [1:0] el, input logic [4:0] ep);
    if (id == 0) begin
      req0_valid = v; req0_sline = sl; req0_spoint = sp; req0_eline = el; req0_epoint = ep;
    end else begin
      req1_valid = v; req1_sline = sl; req1_spoint = sp; req1_eline = el; req1_epoint = ep;
    end
  endtask

  int                 r_lat;
  int                 r_id;
  int                 r_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [PRICE_W-1:0] r_price;
  logic               r_err;

  // Issue one query, then report latency from the accept edge, responder, read strobes and result.
  task automatic applyStimulus(input int id, input logic [1:0] sl, input logic [4:0] sp,
                               input logic [1:0] el, input logic [4:0] ep);
    bit acc = 0;
    @(posedge clk); #1;
    setReq(id, 1, sl, sp, el, ep);
    for (int k = 0; k < 30 && !acc; k++) begin
      @(negedge clk);
      acc = (id == 0) ? req0_ready : req1_ready;
    end
    checkOutput("accept_seen", acc, 1);
    @(posedge clk); #1;
    setReq(id, 0, sl, sp, el, ep);
    r_lat = -1; r_id = -1; r_en = 0; r_addr = '0; r_price = '0; r_err = 0;
    for (int k = 1; k <= 30 && r_id < 0; k++) begin
      @(negedge clk);
      if (ram_en) begin
        r_en++;
        r_addr = ram_addr;
      end
      if (resp0_valid || resp1_valid) begin
        r_id = resp1_valid ? 1 : 0;
        r_lat = k;
        r_price = resp_price;
        r_err = resp_err;
      end
    end
    checkOutput("resp_seen", r_id >= 0, 1);
  endtask

  task automatic doReset(input int n);
    @(posedge clk); #1;
    rst = 1;
    repeat (n) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic run_req(input int id, input int n);
    logic [1:0] sl = '0, el = '0;
    logic [4:0] sp = '0, ep = '0;
    bit v = 0, acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = (id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
      @(posedge clk); #1;
      if (!v || acc) begin
        v = ($urandom_range(0, 2) != 0);
        if (v && $urandom_range(0, 3) != 0) begin
          sl = 2'($urandom_range(0, 3));
          el = 2'($urandom_range(0, 3));
          sp = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, st_len(sl) - 1));
          ep = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, st_len(el) - 1));
          if ($urandom_range(0, 7) == 0) begin
            el = sl; ep = sp;
          end
        end
        setReq(id, v, sl, sp, el, ep);
      end
    end
    setReq(id, 0, sl, sp, el, ep);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int order[$];
    int viol;
    int pulses;
    bit acc;

    // Reset with both requesters asserting: nothing may be granted and all outputs are zero.
    setReq(0, 1, 2'd1, 5'd3, 2'd2, 5'd5);
    setReq(1, 1, 2'd0, 5'd0, 2'd3, 5'd17);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_price,
                                  resp_err, ram_en, ram_addr, busy}, 64'd0);
    @(posedge clk); #1;
    setReq(0, 0, 0, 0, 0, 0);
    setReq(1, 0, 0, 0, 0, 0);
    rst = 0;

    applyStimulus(0, 2'd1, 5'd3, 2'd2, 5'd5);
    checkOutput("t1_latency", r_lat, RAM_LAT + 2);
    checkOutput("t1_resp_id", r_id, 0);
    checkOutput("t1_ram_en_count", r_en, 1);
    checkOutput("t1_ram_addr", r_addr, 3058);
    checkOutput("t1_price", r_price, 7);
    checkOutput("t1_err", r_err, 0);

    applyStimulus(1, 2'd0, 5'd0, 2'd3, 5'd17);
    checkOutput("t2_resp_id", r_id, 1);
    checkOutput("t2_ram_addr", r_addr, 99);
    checkOutput("t2_price", r_price, ram_fn(19'd99));

    applyStimulus(0, 2'd3, 5'd18, 2'd0, 5'd1);
    checkOutput("t3_latency", r_lat, 2);
    checkOutput("t3_ram_en_count", r_en, 0);
    checkOutput("t3_err", r_err, 1);
    checkOutput("t3_price", r_price, 0);

    applyStimulus(0, 2'd2, 5'd4, 2'd2, 5'd4);
    checkOutput("t4_same_station_err", r_err, 1);
    checkOutput("t4_latency", r_lat, 2);

    // Repeat of a query: cache build answers from the cache, plain build reads the RAM again.
    applyStimulus(0, 2'd1, 5'd3, 2'd2, 5'd5);
    checkOutput("rep1_ram_en_count", r_en, 1);
    checkOutput("rep1_price", r_price, 7);
    applyStimulus(0, 2'd1, 5'd3, 2'd2, 5'd5);
    checkOutput("rep2_price", r_price, 7);
`ifdef FARE_CACHE_EN
    checkOutput("rep2_latency", r_lat, 2);
    checkOutput("rep2_ram_en_count", r_en, 0);
`else
    checkOutput("rep2_latency", r_lat, RAM_LAT + 2);
    checkOutput("rep2_ram_en_count", r_en, 1);
`endif
    applyStimulus(0, 2'd1, 5'd3, 2'd2, 5'd6);
    checkOutput("rep3_ram_en_count", r_en, 1);
    checkOutput("rep3_ram_addr", r_addr, 3059);
    checkOutput("rep3_latency", r_lat, RAM_LAT + 2);

    // Both requesters held valid: round-robin from req0 right after reset.
    doReset(2);
    @(posedge clk); #1;
    setReq(0, 1, 2'd0, 5'd1, 2'd1, 5'd1);
    setReq(1, 1, 2'd2, 5'd2, 2'd3, 5'd3);
    viol = 0;
    for (int c = 0; c < 80 && order.size() < 3; c++) begin
      @(negedge clk);
      if ((req0_ready || req1_ready) && busy) viol++;
      if (req0_ready) order.push_back(0);
      if (req1_ready) order.push_back(1);
      @(posedge clk); #1;
    end
    setReq(0, 0, 0, 0, 0, 0);
    setReq(1, 0, 0, 0, 0, 0);
    checkOutput("rr_grant_count", order.size(), 3);
    checkOutput("rr_grant_0", order.size() > 0 ? order[0] : 9, 0);
    checkOutput("rr_grant_1", order.size() > 1 ? order[1] : 9, 1);
    checkOutput("rr_grant_2", order.size() > 2 ? order[2] : 9, 0);
    checkOutput("ready_while_busy", viol, 0);
    repeat (RAM_LAT + 4) @(posedge clk);

    // Reset while a read is in flight: outputs clear and the aborted query never answers.
    @(posedge clk); #1;
    setReq(0, 1, 2'd2, 5'd0, 2'd3, 5'd0);
    acc = 0;
    for (int k = 0; k < 30 && !acc; k++) begin
      @(negedge clk);
      acc = req0_ready;
    end
    checkOutput("abort_accept", acc, 1);
    @(posedge clk); #1;
    setReq(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("abort_outputs_zero", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_price,
                                       resp_err, ram_en, ram_addr, busy}, 64'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) pulses++;
    end
    checkOutput("abort_no_resp", pulses, 0);
    applyStimulus(0, 2'd2, 5'd0, 2'd3, 5'd0);
    checkOutput("after_abort_latency", r_lat, RAM_LAT + 2);
    checkOutput("after_abort_ram_addr", r_addr, 5382);
    checkOutput("after_abort_price", r_price, ram_fn(19'd5382));

    // Random traffic from both requesters with occasional resets, checked by the model every cycle.
    fork
      run_req(0, 3000);
      run_req(1, 3000);
      begin
        for (int c = 0; c < 3000; c++) begin
          @(posedge clk); #1;
          rst = ($urandom_range(0, 199) == 0);
        end
        rst = 0;
      end
    join
    repeat (RAM_LAT + 8) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fare_lookup_ctrl.md
Name: fare_lookup_ctrl

Overview:
Sequencer and arbiter for the shared fare-table RAM port A in the underground ticket machine. It accepts fare queries (start line/point, end line/point) from two requesters: req0 is the ticket-purchase FSM and req1 is the display refresh. It grants them round-robin, validates station coordinates, and forms the table address as start_idx*100 + end_idx. It issues one read, waits the RAM latency, and returns a 12-bit price to the granted requester.

Parameters:
RAM_LAT, 2, cycles from ram_en/ram_addr edge until ram_dout is valid (1..7)
ADDR_W, 19, ram_addr width
PRICE_W, 12, ram_dout/resp_price width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 query pending; held until req0_ready
req0_sline  in  2  start line
req0_spoint  in  5  start point on line
req0_eline  in  2  end line
req0_epoint  in  5  end point on line
req0_ready  out  1  accept strobe; transfer on edge where valid&ready
req1_valid, req1_sline, req1_spoint, req1_eline, req1_epoint, req1_ready  same as req0
resp0_valid  out  1  one-cycle result pulse to requester 0
resp1_valid  out  1  one-cycle result pulse to requester 1
resp_price  out  PRICE_W  price; held until next DONE
resp_err  out  1  query invalid; price forced 0
ram_en  out  1  read enable to fare RAM port A
ram_addr  out  ADDR_W  read address
ram_dout  in  PRICE_W  read data
busy  out  1  high in every state except IDLE

Behaviour:
- Line offsets and lengths:
  - Line 0: offset 0, valid points 0..26.
  - Line 1: offset 27, valid points 0..25.
  - Line 2: offset 53, valid points 0..28.
  - Line 3: offset 82, valid points 0..17.
- idx = offset + point. addr = sidx*100 + eidx, with a maximum of 9999, zero-extended to ADDR_W. No truncation is allowed.
- The query is invalid if either point is out of range for its line, or if sidx == eidx.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req*_ready is combinational. It is asserted only for the granted requester, and only while that requester's valid is high.
  - Grant rule when both are valid: the rr pointer chooses. rr = 0 favours req0.
  - After each accept, rr points to the other requester.
  - On accept, latch the query fields and the requester id, then go to ISSUE.
- ISSUE (1 cycle):
  - Valid query: ram_en = 1 and ram_addr = computed address (registered outputs), then go to WAIT with cnt = RAM_LAT-1.
  - Invalid query: ram_en stays 0, set err, then go to DONE.
- WAIT:
  - Decrement cnt each cycle.
  - When cnt == 0, capture ram_dout into resp_price, clear err, and go to DONE.
  - ram_en is 0 throughout WAIT.
- DONE (1 cycle):
  - respN_valid = 1 for the latched requester only.
  - resp_price/resp_err are stable from this cycle until the next DONE.
  - Next state is IDLE. A new accept is possible on the following cycle.
- Latency, counted from the accept edge:
  - Valid query: resp pulse in cycle RAM_LAT+2.
  - Invalid query: resp pulse in cycle 2.
- req*_ready is never asserted outside IDLE. A valid that arrives while busy waits.
- The controller holds at most one outstanding query.
- Reset, including mid-operation: state = IDLE and rr = 0. All outputs are 0: ready, resp*_valid, resp_price, resp_err, ram_en, ram_addr, busy. A read in flight is discarded and no response is produced.

Optional Feature:
FARE_CACHE_EN:
- When defined:
  - Keep a one-entry cache of the last valid query (sidx, eidx, price) with a valid bit. Reset clears the valid bit.
  - In ISSUE, on a hit, skip the RAM: ram_en stays 0, go straight to DONE, and return the cached price. Latency is 2 cycles.
  - On a miss, follow normal flow and update the cache at capture.
  - Invalid queries never touch the cache.
- When undefined: every valid query reads the RAM. No cache registers exist.

Test Plan:
- req0 line1/pt3 -> line2/pt5, RAM returns 12'd7 at addr 3058 -> ram_en one cycle with ram_addr=3058; resp0_valid in cycle 4 after accept (RAM_LAT=2); resp_price=7; resp_err=0.
- req1 line0/pt0 -> line3/pt17 -> ram_addr=99; resp1_valid only; resp0_valid stays 0.
- req0 line3/pt18 -> line0/pt1 -> no ram_en; resp0_valid in cycle 2; resp_err=1; resp_price=0. Then line2/pt4 -> line2/pt4 (same station) -> resp_err=1.
- req0 and req1 both held valid for 3 queries after reset -> grants in order req0, req1, req0; req*_ready never high while busy=1.
- rst asserted during WAIT -> next cycle all outputs 0; no resp pulse for the aborted query; a fresh query afterwards completes normally.
- FARE_CACHE_EN: same query issued twice -> second has no ram_en, resp in cycle 2 with the identical price; a differing query -> RAM read occurs.
